// File: rtl/divk_tracker.sv
// divk_tracker: running coordinate with live quotient/remainder by DIVISOR.
// Optional DIVK_LIMIT_EN: wrap at LIMIT-1 and reject loads >= LIMIT.
module divk_tracker #(
   parameter int WIDTH   = 10,
   parameter int DIVISOR = 3,
   parameter int LIMIT   = 120,
   parameter int QW      = WIDTH,
   parameter int RW      = $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic [QW-1:0]    quot,
   output logic [RW-1:0]    rem,
   output logic             busy,
   output logic             q_inc,
   output logic             wrap,
   output logic             load_err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [RW:0]   DVP  = (RW+1)'(DIVISOR);
   localparam logic [RW-1:0] RMAX = RW'(DIVISOR-1);

`ifdef DIVK_LIMIT_EN
   localparam logic [WIDTH-1:0] WRAPV = WIDTH'(LIMIT-1);
   localparam logic [WIDTH:0]   LIMV  = (WIDTH+1)'(LIMIT);
`else
   localparam logic [WIDTH-1:0] WRAPV = '1;
`endif

   generate
      if (DIVISOR < 2 || LIMIT < 2 || WIDTH < 2) begin : g_bad
         $error("divk_tracker: bad parameters");
      end
   endgenerate

   typedef enum logic {
      READY,
      DIV
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] ldv;
   logic [RW-1:0]    pr;
   logic [WIDTH-1:0] qs;
   logic [CW-1:0]    cnt;

   logic [RW:0]      trial;
   logic             qbit;
   logic [RW-1:0]    pr_n;
   logic [WIDTH-1:0] qs_n;
   logic             load_ok;

   // One restoring-division step on the next dividend bit.
   always_comb begin
      trial = {pr, dvd[WIDTH-1]};
      qbit  = (trial >= DVP);
      pr_n  = trial[RW-1:0];
      if (qbit) begin
         pr_n = RW'(trial - DVP);
      end
      qs_n  = {qs[WIDTH-2:0], qbit};
   end

`ifdef DIVK_LIMIT_EN
   assign load_ok = ({1'b0, load_value} < LIMV);
`else
   assign load_ok  = 1'b1;
   assign load_err = 1'b0;
`endif

   // Control FSM, incremental step path and serial divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= READY;
         busy     <= 1'b0;
         value    <= '0;
         quot     <= '0;
         rem      <= '0;
         q_inc    <= 1'b0;
         wrap     <= 1'b0;
`ifdef DIVK_LIMIT_EN
         load_err <= 1'b0;
`endif
         dvd      <= '0;
         ldv      <= '0;
         pr       <= '0;
         qs       <= '0;
         cnt      <= '0;
      end else begin
         q_inc    <= 1'b0;
         wrap     <= 1'b0;
`ifdef DIVK_LIMIT_EN
         load_err <= 1'b0;
`endif
         unique case (state)
            READY: begin
               if (load && load_ok) begin
                  dvd   <= load_value;
                  ldv   <= load_value;
                  pr    <= '0;
                  qs    <= '0;
                  cnt   <= CW'(WIDTH-1);
                  busy  <= 1'b1;
                  state <= DIV;
               end
`ifdef DIVK_LIMIT_EN
               else if (load) begin
                  load_err <= 1'b1;
               end
`endif
               else if (step) begin
                  if (value == WRAPV) begin
                     value <= '0;
                     quot  <= '0;
                     rem   <= '0;
                     wrap  <= 1'b1;
                  end else begin
                     value <= value + 1'b1;
                     if (rem == RMAX) begin
                        rem   <= '0;
                        quot  <= quot + 1'b1;
                        q_inc <= 1'b1;
                     end else begin
                        rem <= rem + 1'b1;
                     end
                  end
               end
            end
            DIV: begin
               dvd <= dvd << 1;
               pr  <= pr_n;
               qs  <= qs_n;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  value <= ldv;
                  quot  <= QW'(qs_n);
                  rem   <= pr_n;
                  busy  <= 1'b0;
                  state <= READY;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divk_tracker.sv
// tb_divk_tracker: scoreboard bench with a value/DIVISOR reference model.
// Build with +define+DIVK_LIMIT_EN to exercise the limit variant.
module tb_divk_tracker;

   localparam int WIDTH   = 10;
   localparam int DIVISOR = 3;
   localparam int LIMIT   = 120;
   localparam int QW      = WIDTH;
   localparam int RW      = $clog2(DIVISOR);

`ifdef DIVK_LIMIT_EN
   localparam bit LIM   = 1'b1;
   localparam int WRAPV = LIMIT - 1;
`else
   localparam bit LIM   = 1'b0;
   localparam int WRAPV = (1 << WIDTH) - 1;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             step;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] value;
   logic [QW-1:0]    quot;
   logic [RW-1:0]    rem;
   logic             busy;
   logic             q_inc;
   logic             wrap;
   logic             load_err;

   divk_tracker #(
      .WIDTH(WIDTH),
      .DIVISOR(DIVISOR),
      .LIMIT(LIMIT),
      .QW(QW),
      .RW(RW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .step(step),
      .load(load),
      .load_value(load_value),
      .value(value),
      .quot(quot),
      .rem(rem),
      .busy(busy),
      .q_inc(q_inc),
      .wrap(wrap),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int    due;
      int    v;
      int    q;
      int    r;
      bit    busy;
      bit    qinc;
      bit    wrap;
      bit    lerr;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   int   mv = 0;

   function automatic exp_t mk(int due, int v, bit b, bit qi,
                               bit w, bit le, string tag);
      exp_t e;
      e.due  = due;
      e.v    = v;
      e.q    = v / DIVISOR;
      e.r    = v % DIVISOR;
      e.busy = b;
      e.qinc = qi;
      e.wrap = w;
      e.lerr = le;
      e.tag  = tag;
      return e;
   endfunction

   // Monitor: compare whatever is due this cycle, else pulses must be low.
   exp_t me;
   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            me = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected at cycle %0d, never compared",
                     me.tag, me.due);
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            me = sb.pop_front();
            checks++;
            if (value !== WIDTH'(me.v) || quot !== QW'(me.q) ||
                rem !== RW'(me.r) || busy !== me.busy ||
                q_inc !== me.qinc || wrap !== me.wrap ||
                load_err !== me.lerr) begin
               errors++;
               $display({"FAIL %s cyc=%0d: got v=%0d q=%0d r=%0d b=%b ",
                         "qi=%b w=%b le=%b, want v=%0d q=%0d r=%0d ",
                         "b=%b qi=%b w=%b le=%b"},
                        me.tag, cyc, value, quot, rem, busy, q_inc,
                        wrap, load_err, me.v, me.q, me.r, me.busy,
                        me.qinc, me.wrap, me.lerr);
            end
         end else begin
            checks++;
            if ({q_inc, wrap, load_err} !== 3'b000) begin
               errors++;
               $display("FAIL idle_pulse cyc=%0d: got qi=%b w=%b le=%b, want 000",
                        cyc, q_inc, wrap, load_err);
            end
         end
      end
   end

   task automatic do_step();
      bit w;
      bit qi;
      w = (mv == WRAPV);
      if (w) mv = 0;
      else   mv = mv + 1;
      qi = !w && (mv % DIVISOR == 0);
      sb.push_back(mk(cyc + 1, mv, 1'b0, qi, w, 1'b0, "step"));
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic do_load(int v, bit spam, bit with_step);
      int e0;
      e0 = cyc + 1;
      load = 1'b1;
      load_value = WIDTH'(v);
      step = with_step;
      if (LIM && v >= LIMIT) begin
         sb.push_back(mk(e0, mv, 1'b0, 1'b0, 1'b0, 1'b1, "load_rej"));
         @(negedge clk);
         load = 1'b0;
         step = 1'b0;
      end else begin
         sb.push_back(mk(e0, mv, 1'b1, 1'b0, 1'b0, 1'b0, "busy_start"));
         sb.push_back(mk(e0 + WIDTH - 1, mv, 1'b1, 1'b0, 1'b0, 1'b0,
                         "busy_last"));
         sb.push_back(mk(e0 + WIDTH, v, 1'b0, 1'b0, 1'b0, 1'b0,
                         "load_done"));
         mv = v;
         @(negedge clk);
         load = 1'b0;
         step = 1'b0;
         repeat (WIDTH) begin
            if (spam) begin
               step = 1'($urandom_range(0, 1));
               load = 1'($urandom_range(0, 1));
               load_value = WIDTH'($urandom);
            end
            @(negedge clk);
         end
         step = 1'b0;
         load = 1'b0;
      end
   endtask

   task automatic reset_mid();
      int rv;
      rv = LIM ? 100 : 500;
      sb.push_back(mk(cyc + 1, mv, 1'b1, 1'b0, 1'b0, 1'b0, "div_started"));
      load = 1'b1;
      load_value = WIDTH'(rv);
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      sb.push_back(mk(cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_div"));
      @(negedge clk);
      reset = 1'b0;
      mv = 0;
      do_step();
   endtask

   initial begin
      reset = 1'b1;
      step = 1'b0;
      load = 1'b0;
      load_value = '0;
      @(negedge clk);
      step = 1'b1;
      load = 1'b1;
      load_value = WIDTH'(55);
      sb.push_back(mk(cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset"));
      mon_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step = 1'b0;
      load = 1'b0;
      mv = 0;

      repeat (7) do_step();
      do_load(119, 1'b0, 1'b0);
      do_step();

      do_load(WRAPV, 1'b0, 1'b0);
      do_step();
      do_load(LIMIT, 1'b0, 1'b0);
      do_step();

      do_load(77, 1'b1, 1'b1);
      do_step();

      reset_mid();

      for (int v = 0; v < LIMIT; v++) begin
         do_load(v, 1'b0, 1'b0);
         do_step();
      end

      repeat (300) begin
         int k;
         k = int'($urandom_range(0, 7));
         if (k == 0) begin
            do_load(int'($urandom_range(0, (1 << WIDTH) - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if (k == 1) begin
            @(negedge clk);
         end else begin
            do_step();
         end
      end

      repeat (WIDTH + 4) @(negedge clk);
      while (sb.size() > 0) begin
         me = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: due cycle %0d never reached", me.tag, me.due);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divk_tracker.md
# divk_tracker

Parametrised successor to the fixed divide-by-3 glyph lookup. It tracks a running pixel or character coordinate and always presents its quotient and remainder by a compile-time constant DIVISOR. Unit steps update the quotient and remainder incrementally in a single cycle. Arbitrary loads run a multi-cycle restoring divider. It sits in the VGA glyph path between the horizontal/vertical timing counters and the glyph/ROM address logic, replacing per-width lookup tables.

## Interface

Parameters:
- WIDTH, 10: width of the tracked value and `load_value`.
- DIVISOR, 3: constant divisor, ≥2.
- LIMIT, 120: wrap point, used only with DIVK_LIMIT_EN; 2 ≤ LIMIT ≤ 2^WIDTH.
- QW, WIDTH: quotient width.
- RW, $clog2(DIVISOR): remainder width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  advance tracked value by +1.
- load  in  1  replace tracked value with `load_value`.
- load_value  in  WIDTH  value to load.
- value  out  WIDTH  current tracked value.
- quot  out  QW  value / DIVISOR.
- rem  out  RW  value % DIVISOR.
- busy  out  1  high while a load division is in progress.
- q_inc  out  1  one-cycle pulse: quotient incremented by a step.
- wrap  out  1  one-cycle pulse: step wrapped the value to 0.
- load_err  out  1  one-cycle pulse: load rejected (DIVK_LIMIT_EN only; tied 0 otherwise).

## Operation

- FSM states:
  - READY (busy=0).
  - DIV (busy=1).
- READY, load=1: load wins over step.
  - Latch load_value into dividend shadow; clear partial remainder/quotient shadows; cnt=WIDTH-1.
  - Go to DIV.
- READY, step=1, load=0, value not at wrap point:
  - value+1.
  - If rem==DIVISOR-1: rem=0, quot+1, q_inc=1.
  - Else rem+1.
- READY, step at wrap point: value=0, quot=0, rem=0, wrap=1, q_inc=0.
  - Wrap point is 2^WIDTH-1, or LIMIT-1 with DIVK_LIMIT_EN.
- DIV, one dividend bit per cycle, MSB first (restoring):
  - pr' = {pr, bit}.
  - If pr' ≥ DIVISOR: pr' −= DIVISOR and the quotient bit is 1.
  - Partial remainder is RW+1 bits wide.
- DIV, on the cnt==0 cycle:
  - value, quot and rem update together from the shadows.
  - Return to READY.
- During DIV, value/quot/rem hold their previous results. step and load are ignored and dropped, not queued.
- Quotient bits above QW are truncated. The default QW=WIDTH never truncates.
- q_inc, wrap and load_err are high only for the cycle after the triggering edge.

## Timing

- Reset, next edge: value=0, quot=0, rem=0, busy=0, q_inc=0, wrap=0, load_err=0, FSM=READY.
- Reset overrides load and step in the same cycle.
- Reset during DIV abandons the division. Results are 0, not the loaded value.
- step latency: outputs valid 1 cycle after the sampling edge. Back-to-back steps are allowed every cycle.
- load latency:
  - load sampled at edge E.
  - busy=1 from E through edge E+WIDTH.
  - New value/quot/rem visible after edge E+WIDTH; busy=0 at the same time.
  - Next load or step is accepted at edge E+WIDTH+1.
- Step reaching exactly a multiple of DIVISOR asserts q_inc in the same output cycle as the new quot.

## Configuration

- DIVK_LIMIT_EN defined:
  - step at value LIMIT-1 wraps to 0.
  - A load with load_value ≥ LIMIT is rejected: state unchanged, no DIV entry, load_err pulses 1 cycle.
- DIVK_LIMIT_EN undefined:
  - Wrap occurs at 2^WIDTH-1.
  - All loads are accepted; load_err is constant 0; LIMIT is unused.

## Test plan

- Reset, then 7 consecutive steps (DIVISOR=3) -> (quot,rem) sequence (0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1); q_inc pulses after steps 3 and 6 only.
- load 119 at edge E (WIDTH=10) -> busy high 10 cycles; value=119, quot=39, rem=2 after E+10; busy low.
- Exhaustive: load every 0..LIMIT-1, wait for busy low, then step once -> quot/rem equal value/3 and value%3 for both load result and step result.
- DIVK_LIMIT_EN, LIMIT=120: load 119 then step -> value=0, quot=0, rem=0, wrap=1 for one cycle; load 120 -> load_err=1, state unchanged, busy stays 0.
- Drive step and load every cycle during DIV -> ignored; final result equals first load only; load+step together in READY -> load taken.
- Assert reset at cycle 4 of a division of 500 -> next cycle all outputs 0, busy=0; subsequent step gives value=1.
